// File: rtl/menu_pkg.sv
// Shared menu-subsystem types and helpers: button FSM states and ms-to-cycle conversion.
// Used by button_event, the debouncer instantiation and the menu FSM.
package menu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRESSED,
    LONG,
    LOCKOUT
  } btn_state_t;

  // 64-bit intermediate so that CLK_FREQ * ms cannot overflow before the divide.
  function automatic int unsigned ms_to_cycles(input longint unsigned clk_freq,
                                               input longint unsigned ms);
    longint unsigned cyc;
    cyc = (clk_freq * ms) / 64'd1000;
    return cyc[31:0];
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/btn_edge_detect.sv
// Rise/fall detector for an already-synchronous level; shared with the menu FSM switch inputs.
// The previous-level register loads the live input every cycle, reset included.
module btn_edge_detect (
  input  logic clk,
  input  logic i_level,
  output logic o_rise,
  output logic o_fall
);

  logic r_prev;

  // Reset would load i_level as well, so no reset branch is needed.
  always_ff @(posedge clk) begin
    r_prev <= i_level;
  end

  assign o_rise = i_level & ~r_prev;
  assign o_fall = ~i_level & r_prev;

endmodule

// File: rtl/button_event.sv
// Debounced button level to registered press/release/short/long/repeat pulses plus held level.
// Auto-repeat is compiled in only when BUTTON_AUTO_REPEAT_EN is defined.
module button_event
  import menu_pkg::*;
#(
  parameter int unsigned CLK_FREQ      = 100_000_000,
  parameter int unsigned LONG_PRESS_MS = 1000,
  parameter int unsigned REPEAT_MS     = 200
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic short_press,
  output logic long_press,
  output logic repeat_pulse,
  output logic held
);

  localparam int unsigned LONG_CYC = ms_to_cycles(CLK_FREQ, LONG_PRESS_MS);
`ifdef BUTTON_AUTO_REPEAT_EN
  localparam int unsigned REPEAT_CYC = ms_to_cycles(CLK_FREQ, REPEAT_MS);
  localparam int unsigned CNT_MAX    = max_u(LONG_CYC, REPEAT_CYC);
`else
  localparam int unsigned CNT_MAX    = LONG_CYC;
`endif
  localparam int unsigned CNT_W = $clog2(CNT_MAX) + 1;

  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYC - 1);
`ifdef BUTTON_AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYC - 1);
`endif

  if (LONG_CYC < 2) begin : g_long_chk
    $error("button_event: LONG_CYC must be at least 2");
  end
`ifdef BUTTON_AUTO_REPEAT_EN
  if (REPEAT_CYC < 1) begin : g_repeat_chk
    $error("button_event: REPEAT_CYC must be at least 1");
  end
`endif

  logic w_rise;
  logic w_fall;

  btn_edge_detect u_edge (
    .clk     (clk),
    .i_level (btn_level),
    .o_rise  (w_rise),
    .o_fall  (w_fall)
  );

  btn_state_t       r_state;
  btn_state_t       w_state_next;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_next;

  logic r_press, r_release, r_short, r_long, r_repeat, r_held;
  logic w_press_next, w_release_next, w_short_next, w_long_next, w_repeat_next, w_held_next;

  always_comb begin
    w_state_next   = r_state;
    w_count_next   = r_count;
    w_press_next   = 1'b0;
    w_release_next = 1'b0;
    w_short_next   = 1'b0;
    w_long_next    = 1'b0;
    w_repeat_next  = 1'b0;

    unique case (r_state)
      IDLE: begin
        if (w_rise) begin
          w_state_next = PRESSED;
          w_count_next = '0;
          w_press_next = 1'b1;
        end
      end

      // A fall on the threshold cycle wins: the press is still reported as short.
      PRESSED: begin
        w_count_next = r_count + 1'b1;
        if (w_fall) begin
          w_state_next   = IDLE;
          w_count_next   = '0;
          w_release_next = 1'b1;
          w_short_next   = 1'b1;
        end else if (r_count == LONG_LAST) begin
          w_state_next = LONG;
          w_count_next = '0;
          w_long_next  = 1'b1;
        end
      end

      LONG: begin
`ifdef BUTTON_AUTO_REPEAT_EN
        w_count_next = r_count + 1'b1;
        if (w_fall) begin
          w_state_next   = IDLE;
          w_count_next   = '0;
          w_release_next = 1'b1;
        end else if (r_count == REPEAT_LAST) begin
          w_count_next  = '0;
          w_repeat_next = 1'b1;
        end
`else
        if (w_fall) begin
          w_state_next   = IDLE;
          w_count_next   = '0;
          w_release_next = 1'b1;
        end
`endif
      end

      // Entered only from reset with the button down; wait silently for release.
      LOCKOUT: begin
        if (!btn_level) begin
          w_state_next = IDLE;
        end
      end

      default: begin
        w_state_next = IDLE;
        w_count_next = '0;
      end
    endcase

    // Held spans the release-pulse cycle too.
    w_held_next = (w_state_next == PRESSED) || (w_state_next == LONG) || w_release_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= btn_level ? LOCKOUT : IDLE;
      r_count   <= '0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
      r_short   <= 1'b0;
      r_long    <= 1'b0;
      r_repeat  <= 1'b0;
      r_held    <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_count   <= w_count_next;
      r_press   <= w_press_next;
      r_release <= w_release_next;
      r_short   <= w_short_next;
      r_long    <= w_long_next;
      r_repeat  <= w_repeat_next;
      r_held    <= w_held_next;
    end
  end

  assign press_pulse   = r_press;
  assign release_pulse = r_release;
  assign short_press   = r_short;
  assign long_press    = r_long;
  assign repeat_pulse  = r_repeat;
  assign held          = r_held;

endmodule

// File: tb/tb_button_event.sv
// Directed bench for button_event at CLK_FREQ=1000, LONG_PRESS_MS=10, REPEAT_MS=4 (10/4 cycles).
// Expected pulse cycles are hand-derived per scenario; repeat expectations follow the build macro.
module tb_button_event;

  logic clk;
  logic reset;
  logic btn_level;
  logic press_pulse, release_pulse, short_press, long_press, repeat_pulse, held;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef BUTTON_AUTO_REPEAT_EN
  localparam bit RepOn = 1'b1;
`else
  localparam bit RepOn = 1'b0;
`endif

  button_event #(
    .CLK_FREQ      (1000),
    .LONG_PRESS_MS (10),
    .REPEAT_MS     (4)
  ) u_dut (
    .clk           (clk),
    .reset         (reset),
    .btn_level     (btn_level),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .short_press   (short_press),
    .long_press    (long_press),
    .repeat_pulse  (repeat_pulse),
    .held          (held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [5:0] obs, input logic [5:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got {prs,rel,sht,lng,rep,hld}=%b, expected %b", tag, obs, exp);
    end
  endtask

  // Cycle c starts at the c-th clock edge of the scenario; inputs for cycle c are driven
  // just after that edge, outputs for cycle c are sampled 1 time unit after it.
  // Reset is high in cycles 0-3, plus rst_mid if non-negative. A value of -1 means "none".
  task automatic run_scn(input string name, input int ncyc, input int rst_mid,
                         input int on1, input int off1, input int on2, input int off2,
                         input int p1, input int rel1, input int sh1, input int hend1,
                         input int p2, input int rel2, input int sh2, input int hend2,
                         input int lng, input int r0, input int r1);
    logic [5:0] exp;
    logic       e_prs, e_rel, e_sht, e_lng, e_rep, e_hld;
    for (int c = 0; c < ncyc; c++) begin
      @(posedge clk);
      #1;
      if (c > 0) begin
        e_prs = (c == p1) || (c == p2);
        e_rel = (c == rel1) || (c == rel2);
        e_sht = (c == sh1) || (c == sh2);
        e_lng = (c == lng);
        e_rep = (r0 >= 0) && (c >= r0) && (c <= r1) && (((c - r0) % 4) == 0);
        e_hld = ((p1 >= 0) && (c >= p1) && (c <= hend1)) ||
                ((p2 >= 0) && (c >= p2) && (c <= hend2));
        exp = {e_prs, e_rel, e_sht, e_lng, e_rep, e_hld};
        check_eq($sformatf("%s@%0d", name, c),
                 {press_pulse, release_pulse, short_press, long_press, repeat_pulse, held},
                 exp);
      end
      reset     = (c < 4) || (c == rst_mid);
      btn_level = ((c >= on1) && (c < off1)) || ((c >= on2) && (c < off2));
    end
  endtask

  initial begin
    reset     = 1'b1;
    btn_level = 1'b0;

    // Short press: high cycles 20-24.
    run_scn("short", 40, -1, 20, 25, -1, -1,
            21, 26, 26, 26, -1, -1, -1, -1, -1, -1, -1);

    // Long press with repeats: high cycles 20-44, fall sampled at 45.
    run_scn("long_rep", 60, -1, 20, 45, -1, -1,
            21, 46, -1, 46, -1, -1, -1, -1, 31, RepOn ? 35 : -1, 43);

    // Fall sampled on the long-threshold cycle: reported as short, no long_press.
    run_scn("collide", 45, -1, 20, 30, -1, -1,
            21, 31, 31, 31, -1, -1, -1, -1, -1, -1, -1);

    // Back-to-back: second rise sampled right after returning to IDLE.
    run_scn("b2b", 40, -1, 20, 23, 24, 27,
            21, 24, 24, 24, 25, 28, 28, 28, -1, -1, -1);

    // Held through reset: locked out until release, then a fresh press at 60.
    run_scn("rst_held", 75, -1, 0, 50, 60, 63,
            -1, -1, -1, -1, 61, 64, 64, 64, -1, -1, -1);

    // Reset mid-hold at cycle 33: outputs clear at 34, no release pulse at 41.
    run_scn("rst_mid", 50, 33, 20, 40, -1, -1,
            21, -1, -1, 33, -1, -1, -1, -1, 31, -1, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/button_event.md
Name: button_event

Overview:
- Sits directly downstream of the button debouncer in the menu subsystem.
- Turns one debounced button level into single-cycle event pulses for the menu FSM: press, release, short press, long press and auto-repeat.
- Also provides a "held" level.
- One instance per button; all outputs are registered.

Parameters:
- CLK_FREQ, 100_000_000, system clock frequency in Hz.
- LONG_PRESS_MS, 1000, hold time in ms before long_press fires.
- REPEAT_MS, 200, auto-repeat period in ms after long_press.
- Derived localparams:
  - LONG_CYC = CLK_FREQ*LONG_PRESS_MS/1000
  - REPEAT_CYC = CLK_FREQ*REPEAT_MS/1000
  - Elaboration error if LONG_CYC < 2 or REPEAT_CYC < 1.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- btn_level  input  1  debounced button level, 1 = pressed, already synchronous to clk.
- press_pulse  output  1  one-cycle pulse on accepted press.
- release_pulse  output  1  one-cycle pulse on release of an accepted press.
- short_press  output  1  one-cycle pulse on release before the long threshold.
- long_press  output  1  one-cycle pulse when hold reaches LONG_CYC.
- repeat_pulse  output  1  one-cycle pulse every REPEAT_CYC while held past long.
- held  output  1  level, high from press_pulse until release_pulse, inclusive.

Behaviour:
- Clock and reset:
  - Clock is clk. Reset is reset: synchronous, active-high.
- Reset values:
  - All outputs 0 and count = 0.
  - btn_prev loads btn_level.
  - State = LOCKOUT if btn_level = 1, else IDLE.
  - A button held through reset never produces events until it is released.
- Edges:
  - rise = btn_level & ~btn_prev.
  - fall = ~btn_level & btn_prev.
  - btn_prev updates every cycle.
- States: IDLE, PRESSED, LONG, LOCKOUT.
  - IDLE:
    - On rise → PRESSED, count <= 0.
    - press_pulse = 1 and held = 1 in the next cycle (latency 1 from sampling cycle N to N+1).
  - PRESSED:
    - Count increments each cycle.
    - On fall → IDLE; release_pulse = 1 and short_press = 1 in the same next cycle; held drops the cycle after.
    - Else if count == LONG_CYC-1 → LONG, count <= 0, long_press = 1 next cycle.
    - Fall takes priority over the threshold when both occur in the same cycle, so the release is reported as a short press.
  - LONG:
    - Count increments each cycle.
    - On fall → IDLE with release_pulse only (no short_press).
    - Else if count == REPEAT_CYC-1 → count <= 0 and repeat_pulse = 1 next cycle.
    - Fall takes priority over a repeat in the same cycle.
  - LOCKOUT:
    - No outputs.
    - On btn_level = 0 → IDLE; no release_pulse.
- Timing, with the rise sampled in cycle N:
  - press_pulse at N+1.
  - long_press at N+1+LONG_CYC.
  - repeat_pulse at N+1+LONG_CYC+k*REPEAT_CYC, k ≥ 1.
- Counter:
  - Unsigned, width $clog2(max(LONG_CYC,REPEAT_CYC))+1.
  - Never wraps, because it clears at each threshold.
- Pulse exclusivity:
  - press_pulse never coincides with any other pulse.
  - short_press only coincides with release_pulse.
- Back-to-back presses:
  - A rise sampled in the cycle directly after return to IDLE is accepted normally.
- Reset mid-operation:
  - Aborts with no release or short pulse.
  - Re-enters LOCKOUT if the button is still pressed.

Optional Feature:
- Macro: BUTTON_AUTO_REPEAT_EN.
- Defined:
  - repeat_pulse behaves as above.
  - The REPEAT_CYC counter logic is present.
- Undefined:
  - repeat_pulse is tied 0.
  - LONG stays in place, counting nothing, until fall.
  - The counter is sized by LONG_CYC only.
  - REPEAT_MS is ignored, and its elaboration check is skipped.

Decomposition:
- Package menu_pkg:
  - typedef enum logic [1:0] btn_state_t {IDLE, PRESSED, LONG, LOCKOUT}.
  - function ms_to_cycles(clk_freq, ms).
  - Shared with debounce instantiation and the menu FSM.
- Sub-module btn_edge_detect:
  - Contains the btn_prev register, reset-loaded from the input.
  - Outputs rise and fall.
  - Reused by the menu FSM for switch inputs.

Test Plan (CLK_FREQ=1000, LONG_PRESS_MS=10, REPEAT_MS=4 → LONG_CYC=10, REPEAT_CYC=4; BUTTON_AUTO_REPEAT_EN defined unless noted):
- Short press:
  - Stimulus: btn_level high at cycle 20 for 5 cycles.
  - Response: press_pulse at 21. release_pulse and short_press together at 26. held high cycles 21–26. No long_press.
- Long with repeat:
  - Stimulus: btn_level high at cycle 20, held until cycle 45.
  - Response: press_pulse at 21, long_press at 31, repeat_pulse at 35, 39 and 43. release_pulse at 46, no short_press.
- Threshold collision:
  - Stimulus: btn_level high at cycle 20, low at cycle 30 (fall sampled on the threshold cycle).
  - Response: release_pulse and short_press at 31. No long_press ever.
- Held through reset:
  - Stimulus: btn_level = 1 while reset is high (cycles 0–3) and held until cycle 50, then a new press at cycle 60.
  - Response: zero pulses before cycle 60. press_pulse at 61.
- Reset mid-hold:
  - Stimulus: press at 20, reset high at cycle 33 for 1 cycle, release at 40.
  - Response: all outputs 0 from cycle 34. No release_pulse at 41.
- Repeat compiled out:
  - Stimulus: as "Long with repeat", with BUTTON_AUTO_REPEAT_EN undefined.
  - Response: long_press at 31. repeat_pulse constant 0. release_pulse at 46.
